// File: rtl/iibg_pkg.sv
// Shared constants, FSM state type and RAM address mapping for the IIBG window buffer.
package iibg_pkg;

  localparam int unsigned WIN_SIZE  = 17;
  localparam int unsigned WIN_PTS   = 289;
  localparam int unsigned ADDR_W    = 9;
  localparam int unsigned DATA_W    = 18;
  localparam int unsigned RAM_DEPTH = 2 * WIN_PTS;
  localparam int unsigned RAM_AW    = $clog2(RAM_DEPTH);

  typedef enum logic {StIdle, StServe} iibg_state_e;

  // Banks are packed back to back so the RAM is exactly 2*WIN_PTS deep.
  function automatic logic [RAM_AW-1:0] bank_addr(input logic bank,
                                                  input logic [ADDR_W-1:0] addr);
    return bank ? RAM_AW'(addr) + RAM_AW'(WIN_PTS) : RAM_AW'(addr);
  endfunction

endpackage

// File: rtl/iibg_bank_ram.sv
// Simple dual-port ping-pong bank RAM: one write port, one registered read port.
module iibg_bank_ram
  import iibg_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              wbank_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rbank_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [RAM_DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[bank_addr(wbank_i, waddr_i)] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[bank_addr(rbank_i, raddr_i)];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iibg_window_17x17.sv
// Integral-image window buffer: ping-pong write banks, addressed read port for the
// 17x17 feature controller, window handshake and per-feature read counting.
module iibg_window_17x17
  import iibg_pkg::*;
(
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iWrreq,
  input  logic [DATA_W-1:0] iWrdata,
  output logic              oWrready,
  input  logic              iRdreq,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic              iFull,
  input  logic              iWinDone,
  output logic              oRun,
  output logic [DATA_W-1:0] oRdata,
  output logic              oRdvalid,
  output logic [3:0]        oFeat_cnt,
  output logic              oFeat_valid,
  output logic              oErr
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(WIN_PTS - 1);

  iibg_state_e       state_q, state_d;
  logic [1:0]        full_q, full_d;
  logic              wsel_q, wsel_d;
  logic              rsel_q, rsel_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]        rd_cnt_q, rd_cnt_d;
  logic              rdvalid_q, rdvalid_d;
  logic              oob_q, oob_d;
  logic              err_q, err_d;
  logic [3:0]        feat_cnt_q, feat_cnt_d;
  logic              feat_valid_q, feat_valid_d;

  logic              wr_fire, rd_fire, rd_oob, win_done;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    wr_fire  = iWrreq & oWrready;
    rd_fire  = iRdreq & oRun;
    rd_oob   = iAddr > LastAddr;
    win_done = iWinDone & (state_q == StServe);

    state_d      = state_q;
    full_d       = full_q;
    wsel_d       = wsel_q;
    rsel_d       = rsel_q;
    wr_ptr_d     = wr_ptr_q;
    rd_cnt_d     = rd_cnt_q;
    err_d        = err_q | (rd_fire & rd_oob);
    rdvalid_d    = rd_fire;
    oob_d        = rd_fire & rd_oob;
    feat_cnt_d   = feat_cnt_q;
    feat_valid_d = 1'b0;

    // Release happens before completion so both can land in the same cycle.
    if (win_done) begin
      full_d[rsel_q] = 1'b0;
      rsel_d         = ~rsel_q;
    end

    if (wr_fire) begin
      if (wr_ptr_q == LastAddr) begin
        wr_ptr_d       = '0;
        full_d[wsel_q] = 1'b1;
        wsel_d         = ~wsel_q;
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end

    unique case (state_q)
      StIdle:  if (full_q[rsel_q]) state_d = StServe;
      StServe: if (win_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A read returning in the iFull cycle still belongs to the finishing feature.
    if (iFull) begin
      feat_cnt_d   = (rdvalid_q && rd_cnt_q != 4'hF) ? rd_cnt_q + 4'd1 : rd_cnt_q;
      feat_valid_d = 1'b1;
      rd_cnt_d     = '0;
    end else if (win_done) begin
      rd_cnt_d = '0;
    end else if (rdvalid_q && rd_cnt_q != 4'hF) begin
      rd_cnt_d = rd_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (!iReset_n) begin
      state_q      <= StIdle;
      full_q       <= '0;
      wsel_q       <= 1'b0;
      rsel_q       <= 1'b0;
      wr_ptr_q     <= '0;
      rd_cnt_q     <= '0;
      rdvalid_q    <= 1'b0;
      oob_q        <= 1'b0;
      err_q        <= 1'b0;
      feat_cnt_q   <= '0;
      feat_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      full_q       <= full_d;
      wsel_q       <= wsel_d;
      rsel_q       <= rsel_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_cnt_q     <= rd_cnt_d;
      rdvalid_q    <= rdvalid_d;
      oob_q        <= oob_d;
      err_q        <= err_d;
      feat_cnt_q   <= feat_cnt_d;
      feat_valid_q <= feat_valid_d;
    end
  end

  iibg_bank_ram u_ram (
    .clk_i   (iClk),
    .we_i    (wr_fire),
    .wbank_i (wsel_q),
    .waddr_i (wr_ptr_q),
    .wdata_i (iWrdata),
    .re_i    (rd_fire & ~rd_oob),
    .rbank_i (rsel_q),
    .raddr_i (iAddr),
    .rdata_o (ram_rdata)
  );

  // Gated by reset so every output reads 0 while iReset_n is low.
  assign oWrready    = iReset_n & ~full_q[wsel_q];
  assign oRun        = (state_q == StServe);
  assign oRdata      = (rdvalid_q && !oob_q) ? ram_rdata : '0;
  assign oRdvalid    = rdvalid_q;
  assign oFeat_cnt   = feat_cnt_q;
  assign oFeat_valid = feat_valid_q;
  assign oErr        = err_q;

endmodule

// File: tb/tb_iibg_window_17x17.sv
// Directed self-checking bench for the IIBG window buffer.
module tb_iibg_window_17x17;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        iWrreq;
  logic [17:0] iWrdata;
  logic        oWrready;
  logic        iRdreq;
  logic [8:0]  iAddr;
  logic        iFull;
  logic        iWinDone;
  logic        oRun;
  logic [17:0] oRdata;
  logic        oRdvalid;
  logic [3:0]  oFeat_cnt;
  logic        oFeat_valid;
  logic        oErr;

  int nvec = 0;
  int nmis = 0;

  always #5 iClk = ~iClk;

  iibg_window_17x17 dut (
    .iClk        (iClk),
    .iReset_n    (iReset_n),
    .iWrreq      (iWrreq),
    .iWrdata     (iWrdata),
    .oWrready    (oWrready),
    .iRdreq      (iRdreq),
    .iAddr       (iAddr),
    .iFull       (iFull),
    .iWinDone    (iWinDone),
    .oRun        (oRun),
    .oRdata      (oRdata),
    .oRdvalid    (oRdvalid),
    .oFeat_cnt   (oFeat_cnt),
    .oFeat_valid (oFeat_valid),
    .oErr        (oErr)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic step();
    @(negedge iClk);
  endtask

  task automatic write_window(input int base);
    nvec++;
    if (oWrready !== 1'b1) begin
      nmis++;
      $display("FAIL wrready_before_window base=%0d act=%b exp=1", base, oWrready);
    end
    for (int i = 0; i < 289; i++) begin
      iWrreq  = 1'b1;
      iWrdata = 18'(base + i);
      step();
    end
    iWrreq = 1'b0;
  endtask

  task automatic do_read(input int addr, output logic v, output logic [17:0] d);
    iRdreq = 1'b1;
    iAddr  = 9'(addr);
    step();
    iRdreq = 1'b0;
    v = oRdvalid;
    d = oRdata;
  endtask

  task automatic test_reset();
    iReset_n = 1'b0; iWrreq = 1'b0; iWrdata = '0; iRdreq = 1'b0;
    iAddr = '0; iFull = 1'b0; iWinDone = 1'b0;
    repeat (3) step();
    nvec++;
    if ({oRun, oRdvalid, oFeat_valid, oErr, oWrready} !== 5'b0 || oRdata !== 18'd0 ||
        oFeat_cnt !== 4'd0) begin
      nmis++;
      $display("FAIL reset_outputs run=%b rdv=%b fv=%b err=%b wrr=%b rd=%0d fc=%0d exp=all0",
               oRun, oRdvalid, oFeat_valid, oErr, oWrready, oRdata, oFeat_cnt);
    end
    iReset_n = 1'b1;
    step();
    nvec++;
    if (oWrready !== 1'b1 || oRun !== 1'b0) begin
      nmis++;
      $display("FAIL after_reset wrready=%b run=%b exp wrready=1 run=0", oWrready, oRun);
    end
  endtask

  task automatic test_fill_and_read();
    logic v; logic [17:0] d;
    int addrs [3] = '{0, 144, 288};
    write_window(0);
    nvec++;
    if (oRun !== 1'b0) begin
      nmis++; $display("FAIL run_early act=%b exp=0", oRun);
    end
    step();
    nvec++;
    if (oRun !== 1'b1) begin
      nmis++; $display("FAIL run_rise act=%b exp=1", oRun);
    end
    foreach (addrs[k]) begin
      do_read(addrs[k], v, d);
      nvec++;
      if (v !== 1'b1 || d !== 18'(addrs[k])) begin
        nmis++;
        $display("FAIL bank0_read addr=%0d v=%b d=%0d exp v=1 d=%0d", addrs[k], v, d, addrs[k]);
      end
    end
  endtask

  task automatic test_ping_pong();
    logic v; logic [17:0] d;
    write_window(1000);
    nvec++;
    if (oWrready !== 1'b0) begin
      nmis++; $display("FAIL both_full_wrready act=%b exp=0", oWrready);
    end
    iWinDone = 1'b1;
    step();
    iWinDone = 1'b0;
    nvec++;
    if (oRun !== 1'b0 || oWrready !== 1'b1) begin
      nmis++;
      $display("FAIL windone_gap run=%b wrready=%b exp run=0 wrready=1", oRun, oWrready);
    end
    step();
    nvec++;
    if (oRun !== 1'b1) begin
      nmis++; $display("FAIL run_reassert act=%b exp=1", oRun);
    end
    do_read(5, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd1005) begin
      nmis++; $display("FAIL bank1_read5 v=%b d=%0d exp v=1 d=1005", v, d);
    end
  endtask

  task automatic test_feature_count();
    // Flush the read left over from the previous test: count must be 1.
    iFull = 1'b1;
    step();
    iFull = 1'b0;
    nvec++;
    if (oFeat_valid !== 1'b1 || oFeat_cnt !== 4'd1) begin
      nmis++; $display("FAIL feat_flush fv=%b cnt=%0d exp fv=1 cnt=1", oFeat_valid, oFeat_cnt);
    end
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        nvec++;
        if (oRdvalid !== 1'b1 || oRdata !== 18'(1000 + i - 1)) begin
          nmis++;
          $display("FAIL b2b_read i=%0d v=%b d=%0d exp v=1 d=%0d", i - 1, oRdvalid, oRdata,
                   1000 + i - 1);
        end
      end
      if (i < 8) begin
        iRdreq = 1'b1; iAddr = 9'(i);
      end else begin
        iRdreq = 1'b0; iFull = 1'b1;
      end
      step();
    end
    iFull = 1'b0;
    nvec++;
    if (oFeat_valid !== 1'b1 || oFeat_cnt !== 4'd8) begin
      nmis++; $display("FAIL feat8 fv=%b cnt=%0d exp fv=1 cnt=8", oFeat_valid, oFeat_cnt);
    end
    step();
    nvec++;
    if (oFeat_valid !== 1'b0) begin
      nmis++; $display("FAIL feat_pulse_width fv=%b exp=0", oFeat_valid);
    end
    for (int i = 0; i < 3; i++) begin
      iRdreq = 1'b1; iAddr = 9'(10 + i);
      step();
    end
    iRdreq = 1'b0;
    step();
    iFull = 1'b1;
    step();
    iFull = 1'b0;
    nvec++;
    if (oFeat_valid !== 1'b1 || oFeat_cnt !== 4'd3) begin
      nmis++; $display("FAIL feat3 fv=%b cnt=%0d exp fv=1 cnt=3", oFeat_valid, oFeat_cnt);
    end
  endtask

  task automatic test_oob();
    logic v; logic [17:0] d;
    do_read(300, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd0 || oErr !== 1'b1) begin
      nmis++; $display("FAIL oob v=%b d=%0d err=%b exp v=1 d=0 err=1", v, d, oErr);
    end
    do_read(2, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd1002 || oErr !== 1'b1) begin
      nmis++; $display("FAIL err_sticky v=%b d=%0d err=%b exp v=1 d=1002 err=1", v, d, oErr);
    end
  endtask

  task automatic test_blocked();
    logic v; logic [17:0] d;
    iWinDone = 1'b1;
    step();
    iWinDone = 1'b0;
    step();
    nvec++;
    if (oRun !== 1'b0) begin
      nmis++; $display("FAIL idle_run act=%b exp=0", oRun);
    end
    iRdreq = 1'b1; iAddr = 9'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if (oRdvalid !== 1'b0) begin
        nmis++; $display("FAIL read_while_idle cyc=%0d v=%b exp=0", i, oRdvalid);
      end
    end
    iRdreq = 1'b0;
    write_window(2000);
    write_window(3000);
    for (int i = 0; i < 5; i++) begin
      nvec++;
      if (oWrready !== 1'b0) begin
        nmis++; $display("FAIL blocked_wrready cyc=%0d act=%b exp=0", i, oWrready);
      end
      iWrreq = 1'b1; iWrdata = 18'd12345;
      step();
    end
    iWrreq = 1'b0;
    iWinDone = 1'b1;
    step();
    iWinDone = 1'b0;
    step();
    do_read(0, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd3000) begin
      nmis++; $display("FAIL bank1_after_block v=%b d=%0d exp v=1 d=3000", v, d);
    end
    do_read(288, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd3288) begin
      nmis++; $display("FAIL bank1_last v=%b d=%0d exp v=1 d=3288", v, d);
    end
    write_window(4000);
    nvec++;
    if (oWrready !== 1'b0) begin
      nmis++; $display("FAIL wrptr_held_full act=%b exp=0", oWrready);
    end
    iWinDone = 1'b1;
    step();
    iWinDone = 1'b0;
    step();
    do_read(0, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd4000) begin
      nmis++; $display("FAIL bank0_first v=%b d=%0d exp v=1 d=4000", v, d);
    end
    do_read(288, v, d);
    nvec++;
    if (v !== 1'b1 || d !== 18'd4288) begin
      nmis++; $display("FAIL bank0_last v=%b d=%0d exp v=1 d=4288", v, d);
    end
  endtask

  task automatic test_reset_mid();
    logic v; logic [17:0] d;
    int addrs [3] = '{0, 99, 288};
    for (int i = 0; i < 100; i++) begin
      iWrreq = 1'b1; iWrdata = 18'(7000 + i);
      step();
    end
    iWrreq = 1'b0;
    iReset_n = 1'b0;
    repeat (2) step();
    nvec++;
    if ({oRun, oRdvalid, oFeat_valid, oErr, oWrready} !== 5'b0 || oRdata !== 18'd0 ||
        oFeat_cnt !== 4'd0) begin
      nmis++;
      $display("FAIL midreset_outputs run=%b rdv=%b fv=%b err=%b wrr=%b rd=%0d fc=%0d exp=all0",
               oRun, oRdvalid, oFeat_valid, oErr, oWrready, oRdata, oFeat_cnt);
    end
    iReset_n = 1'b1;
    step();
    write_window(5000);
    nvec++;
    if (oRun !== 1'b0) begin
      nmis++; $display("FAIL post_reset_run_early act=%b exp=0", oRun);
    end
    step();
    nvec++;
    if (oRun !== 1'b1) begin
      nmis++; $display("FAIL post_reset_run act=%b exp=1", oRun);
    end
    foreach (addrs[k]) begin
      do_read(addrs[k], v, d);
      nvec++;
      if (v !== 1'b1 || d !== 18'(5000 + addrs[k]) || oErr !== 1'b0) begin
        nmis++;
        $display("FAIL post_reset_read addr=%0d v=%b d=%0d err=%b exp v=1 d=%0d err=0",
                 addrs[k], v, d, oErr, 5000 + addrs[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_and_read();
    test_ping_pong();
    test_feature_count();
    test_oob();
    test_blocked();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
